hid_tx: RTL and testbench

// Initiator side of the IO-MCU HID byte protocol: turns queued HID events into

---
 rtl/hid_tx_if.sv | 30 +++
 rtl/hid_tx.sv | 248 ++++++++++++++++++++++++
 tb/tb_hid_tx.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/hid_tx_if.sv
// hid_tx_if -- signal bundle between an HID event source / receiver pair and hid_tx.
//   Event side : ev_valid, ev_ready, ev_type[1:0], ev_data[23:0]
//   Byte side  : strobe, start, data[7:0] towards the receiver, resp_in[7:0] back from it
//   Status     : status_valid, status_data[15:0], busy
// Modports:
//   slave  - used by hid_tx (consumes events, produces bytes/status)
//   master - used by whatever drives events and supplies the response byte
interface hid_tx_if;
   logic        ev_valid;
   logic        ev_ready;
   logic [1:0]  ev_type;
   logic [23:0] ev_data;
   logic        strobe;
   logic        start;
   logic [7:0]  data;
   logic [7:0]  resp_in;
   logic        status_valid;
   logic [15:0] status_data;
   logic        busy;

   modport slave (
      input  ev_valid, ev_type, ev_data, resp_in,
      output ev_ready, strobe, start, data, status_valid, status_data, busy
   );

   modport master (
      output ev_valid, ev_type, ev_data, resp_in,
      input  ev_ready, strobe, start, data, status_valid, status_data, busy
   );
endinterface

// File: rtl/hid_tx.sv
// hid_tx -- initiator side of the IO-MCU HID byte protocol.
// Queued HID events are turned into command frames of one-cycle byte strobes,
// the command byte flagged with start. For status frames the receiver's
// data_out byte (resp_in) is sampled to build the returned status word.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      hid_tx_if.slave: event handshake, byte strobe outputs,
//            response input, status outputs, busy
// Parameters:
//   GAP         idle cycles after every strobe (>=2)
//   FIFO_DEPTH  event queue entries, power of two (>=2)
module hid_tx #(
   parameter int GAP        = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic     clk,
   input  logic     reset_n,
   hid_tx_if.slave  bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      WAIT = 2'd3
   } state_t;

   // ---------------------------------------------------------------
   // Event queue: {type, payload} entries, registered read port
   // ---------------------------------------------------------------
   logic [25:0]   mem [FIFO_DEPTH];
   logic [25:0]   rd_data_q;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ev_ready_q, ev_ready_d;
   logic          push, pop;

   // ---------------------------------------------------------------
   // Frame state
   // ---------------------------------------------------------------
   state_t        state_q, state_d;
   logic [1:0]    type_q, type_d;
   logic [23:0]   pay_q, pay_d;
   logic [1:0]    idx_q, idx_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [7:0]    data_q, data_d;
   logic [15:0]   stat_q, stat_d;
   logic          sv_q, sv_d;
   logic [1:0]    last_idx;
   logic          last_wait;

   // Byte i of a frame of type t with payload p.
   function automatic logic [7:0] frame_byte(input logic [1:0] t,
                                             input logic [23:0] p,
                                             input logic [1:0] i);
      logic [7:0] b;
      b = 8'h00;
      if (i == 2'd0) begin
         b = {6'b0, t};
      end else begin
         case (t)
            2'd1: b = p[7:0];
            2'd2: begin
               case (i)
                  2'd1:    b = {6'b0, p[1:0]};
                  2'd2:    b = p[15:8];
                  default: b = p[23:16];
               endcase
            end
            2'd3: b = (i == 2'd1) ? p[7:0] : p[15:8];
            default: b = 8'h00;
         endcase
      end
      return b;
   endfunction

   // ready comes from the registered count only, so a pop in the same cycle
   // never lets a write into a full queue.
   assign push = bus.ev_valid && ev_ready_q;
   assign pop  = (state_q == LOAD);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= {bus.ev_type, bus.ev_data};
      end
      rd_data_q <= mem[rd_ptr_q];
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      ev_ready_d = (count_d != CNT_FULL);
   end

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      case (type_q)
         2'd0:    last_idx = 2'd2;
         2'd1:    last_idx = 2'd1;
         2'd2:    last_idx = 2'd3;
         default: last_idx = 2'd2;
      endcase
   end

   assign last_wait = (state_q == WAIT) && (gap_q == GAP_LAST);

   // ---------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (count_q != '0) state_d = LOAD;
         LOAD: state_d = SEND;
         SEND: state_d = WAIT;
         WAIT: begin
            if (last_wait) begin
               if (idx_q != last_idx) begin
                  state_d = SEND;
               end else if (count_q != '0) begin
                  state_d = LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath next values
   // ---------------------------------------------------------------
   always_comb begin
      type_d = type_q;
      pay_d  = pay_q;
      idx_d  = idx_q;
      gap_d  = gap_q;
      data_d = data_q;
      stat_d = stat_q;
      sv_d   = 1'b0;
      case (state_q)
         LOAD: begin
            type_d = rd_data_q[25:24];
            pay_d  = rd_data_q[23:0];
            idx_d  = 2'd0;
            data_d = frame_byte(rd_data_q[25:24], rd_data_q[23:0], 2'd0);
         end
         SEND: gap_d = '0;
         WAIT: begin
            gap_d = gap_q + GAP_ONE;
            if (last_wait) begin
               // Status frames: the receiver's answer to payload byte 1/2 is
               // settled by the end of the gap that follows it.
               if (type_q == 2'd0 && idx_q == 2'd1) begin
                  stat_d[15:8] = bus.resp_in;
               end
               if (type_q == 2'd0 && idx_q == 2'd2) begin
                  stat_d[7:0] = bus.resp_in;
                  sv_d        = 1'b1;
               end
               if (idx_q != last_idx) begin
                  idx_d  = idx_q + 2'd1;
                  data_d = frame_byte(type_q, pay_q, idx_q + 2'd1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ev_ready_q <= 1'b0;
         type_q     <= 2'd0;
         pay_q      <= 24'h0;
         idx_q      <= 2'd0;
         gap_q      <= '0;
         data_q     <= 8'h00;
         stat_q     <= 16'h0000;
         sv_q       <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ev_ready_q <= ev_ready_d;
         type_q     <= type_d;
         pay_q      <= pay_d;
         idx_q      <= idx_d;
         gap_q      <= gap_d;
         data_q     <= data_d;
         stat_q     <= stat_d;
         sv_q       <= sv_d;
      end
   end

   // ---------------------------------------------------------------
   // FSM: outputs (decoded from reset-cleared state, so they drop
   // asynchronously with reset_n)
   // ---------------------------------------------------------------
   always_comb begin
      bus.strobe       = (state_q == SEND);
      bus.start        = (state_q == SEND) && (idx_q == 2'd0);
      bus.data         = data_q;
      bus.ev_ready     = ev_ready_q;
      bus.status_valid = sv_q;
      bus.status_data  = stat_q;
      bus.busy         = (count_q != '0) || (state_q != IDLE);
   end

endmodule

// File: tb/tb_hid_tx.sv
module tb_hid_tx;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   hid_tx_if bus();

   hid_tx #(.GAP(4), .FIFO_DEPTH(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int vec = 0;
   int errs = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor: every strobed byte as {start, data} plus its cycle.
   logic [8:0] byte_q[$];
   int         bcyc_q[$];
   int         sv_pulses = 0;
   int         bad_start = 0;
   bit         saw_full = 0;

   always @(negedge clk) begin
      if (bus.strobe) begin
         byte_q.push_back({bus.start, bus.data});
         bcyc_q.push_back(cyc);
      end
      if (bus.status_valid) sv_pulses++;
      if (bus.start && !bus.strobe) bad_start++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("vec %0d %s observed=%0h expected=%0h", vec, tag, obs, exp);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Offer one event; keep=1 leaves ev_valid high for a following push.
   task automatic push(input logic [1:0] t, input logic [23:0] d, input bit keep, output int acc);
      int g;
      g = 0;
      @(negedge clk);
      bus.ev_type  = t;
      bus.ev_data  = d;
      bus.ev_valid = 1'b1;
      while (!bus.ev_ready && g < 2000) begin
         saw_full = 1;
         @(negedge clk);
         g++;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      if (!keep) bus.ev_valid = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input string tag);
      int g;
      g = 0;
      while (byte_q.size() < n && g < 3000) begin
         step();
         g++;
      end
      check(tag, 32'(byte_q.size() >= n), 1);
   endtask

   task automatic wait_idle(input string tag);
      int g;
      g = 0;
      while (bus.busy && g < 3000) begin
         step();
         g++;
      end
      check(tag, 32'(bus.busy), 0);
   endtask

   int acc;
   int b;
   int sv0;

   initial begin
      bus.ev_valid = 1'b0;
      bus.ev_type  = 2'd0;
      bus.ev_data  = 24'h0;
      bus.resp_in  = 8'h00;

      // ---- reset state ----
      #2 reset_n = 1'b0;
      #1;
      check("rst_strobe", 32'(bus.strobe), 0);
      check("rst_start", 32'(bus.start), 0);
      check("rst_data", 32'(bus.data), 32'h00);
      check("rst_ready", 32'(bus.ev_ready), 0);
      check("rst_sv", 32'(bus.status_valid), 0);
      check("rst_sd", 32'(bus.status_data), 32'h0000);
      check("rst_busy", 32'(bus.busy), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_rst", 32'(bus.ev_ready), 1);

      // ---- 1: key 8A, latency and strobe spacing ----
      b = byte_q.size();
      sv0 = sv_pulses;
      push(2'd1, 24'h00008A, 0, acc);
      wait_bytes(b + 2, "key_count");
      check("key_b0", 32'(byte_q[b]), 32'h101);
      check("key_b1", 32'(byte_q[b+1]), 32'h08A);
      check("key_latency", 32'(bcyc_q[b] - acc), 2);
      check("key_period", 32'(bcyc_q[b+1] - bcyc_q[b]), 5);
      wait_idle("key_idle");
      check("key_hold_data", 32'(bus.data), 32'h8A);
      check("key_no_sv", 32'(sv_pulses - sv0), 0);

      // ---- 2: mouse FB0502 ----
      b = byte_q.size();
      push(2'd2, 24'hFB0502, 0, acc);
      wait_bytes(b + 4, "mouse_count");
      check("mouse_b0", 32'(byte_q[b]), 32'h102);
      check("mouse_b1", 32'(byte_q[b+1]), 32'h002);
      check("mouse_b2", 32'(byte_q[b+2]), 32'h005);
      check("mouse_b3", 32'(byte_q[b+3]), 32'h0FB);
      wait_idle("mouse_idle");

      // ---- 3: status frame, response 5C then 42 ----
      b = byte_q.size();
      sv0 = sv_pulses;
      bus.resp_in = 8'h5C;
      push(2'd0, 24'hABCDEF, 0, acc);
      wait_bytes(b + 3, "stat_count");
      bus.resp_in = 8'h42;
      wait_idle("stat_idle");
      repeat (2) step();
      check("stat_b0", 32'(byte_q[b]), 32'h100);
      check("stat_b1", 32'(byte_q[b+1]), 32'h000);
      check("stat_b2", 32'(byte_q[b+2]), 32'h000);
      check("stat_pulses", 32'(sv_pulses - sv0), 1);
      check("stat_data", 32'(bus.status_data), 32'h5C42);

      // ---- 4: eight back-to-back keys 10..17 into a 4-deep queue ----
      b = byte_q.size();
      sv0 = sv_pulses;
      saw_full = 0;
      for (int k = 0; k < 8; k++) begin
         push(2'd1, 24'(8'h10 + k), (k != 7), acc);
      end
      check("burst_full_seen", 32'(saw_full), 1);
      wait_bytes(b + 16, "burst_count");
      wait_idle("burst_idle");
      check("burst_total", 32'(byte_q.size() - b), 16);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("burst_cmd%0d", k), 32'(byte_q[b+2*k]), 32'h101);
         check($sformatf("burst_key%0d", k), 32'(byte_q[b+2*k+1]), 32'(8'h10 + k));
      end
      check("burst_frame_gap", 32'(bcyc_q[b+2] - bcyc_q[b+1] >= 6), 1);
      check("burst_no_sv", 32'(sv_pulses - sv0), 0);

      // ---- 5: reset during mouse dx strobe ----
      b = byte_q.size();
      push(2'd2, 24'hFB0502, 0, acc);
      wait_bytes(b + 3, "rstmid_reach_dx");
      check("rstmid_strobe_before", 32'(bus.strobe), 1);
      reset_n = 1'b0;
      #1;
      check("rstmid_strobe", 32'(bus.strobe), 0);
      check("rstmid_start", 32'(bus.start), 0);
      check("rstmid_busy", 32'(bus.busy), 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (20) step();
      check("rstmid_quiet", 32'(byte_q.size() - b), 3);
      b = byte_q.size();
      push(2'd1, 24'h00008A, 0, acc);
      wait_bytes(b + 2, "rstmid_key_count");
      check("rstmid_key_b0", 32'(byte_q[b]), 32'h101);
      check("rstmid_key_b1", 32'(byte_q[b+1]), 32'h08A);
      wait_idle("rstmid_idle");

      // ---- 6: joystick 001F01 ----
      b = byte_q.size();
      push(2'd3, 24'h001F01, 0, acc);
      wait_bytes(b + 3, "joy_count");
      check("joy_b0", 32'(byte_q[b]), 32'h103);
      check("joy_b1", 32'(byte_q[b+1]), 32'h001);
      check("joy_b2", 32'(byte_q[b+2]), 32'h01F);
      wait_idle("joy_idle");
      check("joy_total", 32'(byte_q.size() - b), 3);

      check("start_without_strobe", 32'(bad_start), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
